// File: rtl/iter_divider_if.sv
// Request/response bundle between the decode stage and the iterative divider.
// The requester uses the master modport; the divider uses the slave modport.
interface iter_divider_if #(
  parameter int unsigned DATA_WIDTH = 32
);
  logic                  div;
  logic                  div_signed;
  logic [DATA_WIDTH-1:0] div_x;
  logic [DATA_WIDTH-1:0] div_y;
  logic                  complete;
  logic [DATA_WIDTH-1:0] div_q;
  logic [DATA_WIDTH-1:0] div_r;
  logic                  busy;

  modport master (
    output div, div_signed, div_x, div_y,
    input  complete, div_q, div_r, busy
  );

  modport slave (
    input  div, div_signed, div_x, div_y,
    output complete, div_q, div_r, busy
  );
endinterface

// File: rtl/iter_divider.sv
// Radix-2 restoring divider: one quotient bit per cycle, magnitudes divided then sign corrected.
// Optional ITER_DIVIDER_EARLY_OUT_EN: finish immediately when |x| < |y| (nonzero divisor).
module iter_divider #(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned CNT_WIDTH  = 6
) (
  input logic           clk,
  input logic           resetn,
  iter_divider_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StCalc, StDone} state_e;

  state_e state_q, state_d;

  logic [DATA_WIDTH-1:0] dvd_q;    // dividend bits shift out, quotient bits shift in
  logic [DATA_WIDTH-1:0] y_abs_q;
  logic [DATA_WIDTH-1:0] rem_q;
  logic [CNT_WIDTH-1:0]  cnt_q;
  logic                  q_neg_q;
  logic                  r_neg_q;
  logic [DATA_WIDTH-1:0] q_out_q;
  logic [DATA_WIDTH-1:0] r_out_q;

  logic [DATA_WIDTH-1:0] x_abs;
  logic [DATA_WIDTH-1:0] y_abs;
  logic                  x_neg;
  logic                  y_neg;
  logic [DATA_WIDTH:0]   shifted;
  logic [DATA_WIDTH+1:0] diff;
  logic                  q_bit;
  logic [DATA_WIDTH-1:0] rem_next;
  logic [DATA_WIDTH-1:0] quo_next;
  logic                  last_iter;
  logic                  start_early;
  logic                  unused_diff;

  assign x_neg = bus.div_signed & bus.div_x[DATA_WIDTH-1];
  assign y_neg = bus.div_signed & bus.div_y[DATA_WIDTH-1];
  assign x_abs = x_neg ? -bus.div_x : bus.div_x;
  assign y_abs = y_neg ? -bus.div_y : bus.div_y;

  // A non-negative trial difference is always below |y| (or below 2^W for y=0),
  // so its bit W never matters.
  assign shifted     = {rem_q, dvd_q[DATA_WIDTH-1]};
  assign diff        = {1'b0, shifted} - {2'b00, y_abs_q};
  assign q_bit       = ~diff[DATA_WIDTH+1];
  assign rem_next    = q_bit ? diff[DATA_WIDTH-1:0] : shifted[DATA_WIDTH-1:0];
  assign quo_next    = {dvd_q[DATA_WIDTH-2:0], q_bit};
  assign last_iter   = (cnt_q == CNT_WIDTH'(DATA_WIDTH - 1));
  assign unused_diff = diff[DATA_WIDTH];

`ifdef ITER_DIVIDER_EARLY_OUT_EN
  assign start_early = (y_abs != '0) && (x_abs < y_abs);
`else
  assign start_early = 1'b0;
`endif

  always_ff @(posedge clk) begin
    if (!resetn) begin
      state_q <= StIdle;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle: begin
        if (bus.div) begin
          state_d = start_early ? StDone : StCalc;
        end
      end
      StCalc: begin
        if (last_iter) begin
          state_d = StDone;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!resetn) begin
      dvd_q   <= '0;
      y_abs_q <= '0;
      rem_q   <= '0;
      cnt_q   <= '0;
      q_neg_q <= 1'b0;
      r_neg_q <= 1'b0;
      q_out_q <= '0;
      r_out_q <= '0;
    end else begin
      unique case (state_q)
        StIdle: begin
          if (bus.div) begin
            dvd_q   <= x_abs;
            y_abs_q <= y_abs;
            rem_q   <= '0;
            cnt_q   <= '0;
            q_neg_q <= x_neg ^ y_neg;
            r_neg_q <= x_neg;
            // Early result: remainder is the raw dividend, already carrying its sign.
            if (start_early) begin
              q_out_q <= '0;
              r_out_q <= bus.div_x;
            end
          end
        end
        StCalc: begin
          dvd_q <= quo_next;
          rem_q <= rem_next;
          cnt_q <= cnt_q + 1'b1;
          if (last_iter) begin
            q_out_q <= q_neg_q ? -quo_next : quo_next;
            r_out_q <= r_neg_q ? -rem_next : rem_next;
          end
        end
        default: ;
      endcase
    end
  end

  assign bus.complete = (state_q == StDone);
  assign bus.busy     = (state_q != StIdle);
  assign bus.div_q    = q_out_q;
  assign bus.div_r    = r_out_q;

endmodule

// File: tb/tb_iter_divider.sv
// Self-checking bench for iter_divider: arithmetic reference model checked every cycle,
// plus directed operations with hand-computed results and latencies.
module tb_iter_divider;
  localparam int unsigned DW = 32;
`ifdef ITER_DIVIDER_EARLY_OUT_EN
  localparam bit EARLY = 1'b1;
`else
  localparam bit EARLY = 1'b0;
`endif

  logic clk = 1'b0;
  logic resetn = 1'b0;
  always #5 clk = ~clk;

  iter_divider_if #(.DATA_WIDTH(DW)) bus ();

  iter_divider #(
    .DATA_WIDTH(DW),
    .CNT_WIDTH (6)
  ) dut (
    .clk   (clk),
    .resetn(resetn),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      if (bad <= 40) $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Reference result {q, r} straight from integer division semantics.
  function automatic logic [63:0] ref_div(input logic [31:0] x, input logic [31:0] y,
                                          input logic s);
    longint xv, yv;
    logic [31:0] q, r, xm;
    xv = s ? {{32{x[31]}}, x} : {32'b0, x};
    yv = s ? {{32{y[31]}}, y} : {32'b0, y};
    if (y == 0) begin
      xm = (s && x[31]) ? -x : x;
      q  = (s && x[31]) ? 32'd1 : 32'hFFFF_FFFF;
      r  = (s && x[31]) ? -xm : xm;
    end else begin
      q = 32'(xv / yv);
      r = 32'(xv % yv);
    end
    return {q, r};
  endfunction

  function automatic bit takes_early(input logic [31:0] x, input logic [31:0] y, input logic s);
    logic [31:0] xm, ym;
    xm = (s && x[31]) ? -x : x;
    ym = (s && y[31]) ? -y : y;
    return EARLY && (y != 0) && (xm < ym);
  endfunction

  // Model: cycles left in the current operation; 1 means the complete cycle.
  int          left   = 0;
  logic [31:0] m_q    = '0;
  logic [31:0] m_r    = '0;
  logic [63:0] p_qr   = '0;
  bit          chk_en = 1'b0;

  always @(posedge clk) begin
    if (!resetn) begin
      left   <= 0;
      m_q    <= '0;
      m_r    <= '0;
      chk_en <= 1'b1;
    end else if (left > 0) begin
      left <= left - 1;
      if (left == 2) begin
        m_q <= p_qr[63:32];
        m_r <= p_qr[31:0];
      end
    end else if (bus.div) begin
      p_qr <= ref_div(bus.div_x, bus.div_y, bus.div_signed);
      if (takes_early(bus.div_x, bus.div_y, bus.div_signed)) begin
        left <= 1;
        m_q  <= '0;
        m_r  <= bus.div_x;
      end else begin
        left <= DW + 1;
      end
    end
  end

  always @(negedge clk) begin
    if (chk_en) begin
      check("cyc_busy", {31'b0, bus.busy}, {31'b0, left > 0});
      check("cyc_complete", {31'b0, bus.complete}, {31'b0, left == 1});
      check("cyc_div_q", bus.div_q, m_q);
      check("cyc_div_r", bus.div_r, m_r);
    end
  end

  task automatic start_op(input logic [31:0] x, input logic [31:0] y, input logic s);
    @(negedge clk);
    bus.div        = 1'b1;
    bus.div_x      = x;
    bus.div_y      = y;
    bus.div_signed = s;
  endtask

  // Waits for complete; drops div at negedge drop_at and scrambles div_x mid-operation.
  task automatic wait_done(input string name, input logic [31:0] eq, input logic [31:0] er,
                           input int elat, input int ebusy, input int drop_at);
    int n = 0;
    int busy_cnt = 0;
    bit done = 1'b0;
    while (!done && n < 150) begin
      @(negedge clk);
      n++;
      if (n == drop_at) bus.div = 1'b0;
      if (n == 5) bus.div_x = '0;
      if (bus.busy) busy_cnt++;
      if (bus.complete) done = 1'b1;
    end
    check({name, "_lat"}, n, elat);
    check({name, "_busy_cycles"}, busy_cnt, ebusy);
    check({name, "_q"}, bus.div_q, eq);
    check({name, "_r"}, bus.div_r, er);
  endtask

  task automatic run_div(input string name, input logic [31:0] x, input logic [31:0] y,
                         input logic s, input logic [31:0] eq, input logic [31:0] er,
                         input int elat);
    start_op(x, y, s);
    wait_done(name, eq, er, elat, elat, 1);
  endtask

  int ncomp;

  initial begin
    bus.div        = 1'b0;
    bus.div_signed = 1'b0;
    bus.div_x      = '0;
    bus.div_y      = '0;
    repeat (3) @(negedge clk);
    check("rst_q", bus.div_q, 32'h0);
    check("rst_r", bus.div_r, 32'h0);
    check("rst_busy", {31'b0, bus.busy}, 32'h0);
    check("rst_complete", {31'b0, bus.complete}, 32'h0);
    resetn = 1'b1;

    run_div("u100_7", 32'd100, 32'd7, 1'b0, 32'd14, 32'd2, 33);
    run_div("s-100_7", 32'hFFFF_FF9C, 32'd7, 1'b1, 32'hFFFF_FFF2, 32'hFFFF_FFFE, 33);
    run_div("s100_-7", 32'd100, 32'hFFFF_FFF9, 1'b1, 32'hFFFF_FFF2, 32'd2, 33);
    run_div("s_ovf", 32'h8000_0000, 32'hFFFF_FFFF, 1'b1, 32'h8000_0000, 32'h0, 33);
    run_div("u_max_1", 32'hFFFF_FFFF, 32'd1, 1'b0, 32'hFFFF_FFFF, 32'h0, 33);
    run_div("u7_0", 32'd7, 32'd0, 1'b0, 32'hFFFF_FFFF, 32'd7, 33);
    run_div("s-7_0", 32'hFFFF_FFF9, 32'd0, 1'b1, 32'h0000_0001, 32'hFFFF_FFF9, 33);

    // div held through DONE, dropped in the following IDLE cycle.
    start_op(32'd50, 32'd5, 1'b0);
    wait_done("hold50_5", 32'd10, 32'd0, 33, 33, 0);
    @(negedge clk);
    bus.div = 1'b0;
    run_div("u9_4", 32'd9, 32'd4, 1'b0, 32'd2, 32'd1, 33);

    // True back-to-back: request already high during the DONE cycle.
    bus.div   = 1'b1;
    bus.div_x = 32'd20;
    bus.div_y = 32'd6;
    wait_done("b2b20_6", 32'd3, 32'd2, 34, 33, 2);

    // Reset in the middle of CALC discards the operation.
    start_op(32'd1000, 32'd3, 1'b0);
    @(negedge clk);
    bus.div = 1'b0;
    repeat (9) @(negedge clk);
    resetn = 1'b0;
    @(negedge clk);
    check("midrst_q", bus.div_q, 32'h0);
    check("midrst_r", bus.div_r, 32'h0);
    check("midrst_busy", {31'b0, bus.busy}, 32'h0);
    check("midrst_complete", {31'b0, bus.complete}, 32'h0);
    resetn = 1'b1;
    ncomp = 0;
    repeat (40) begin
      @(negedge clk);
      if (bus.complete) ncomp++;
    end
    check("midrst_no_complete", ncomp, 0);

    run_div("u3_10", 32'd3, 32'd10, 1'b0, 32'd0, 32'd3, EARLY ? 1 : 33);
    run_div("s-3_10", 32'hFFFF_FFFD, 32'd10, 1'b1, 32'd0, 32'hFFFF_FFFD, EARLY ? 1 : 33);

    repeat (3) @(negedge clk);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
